cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// Shares one word-serial memory port between I-cache refills (read-only) and D-cache refills/write-backs.
// Accepts cache-side rd_*/wr_* handshakes, serialises them (one transaction outstanding), converts
// 128-bit line write-backs to W beats, routes returned beats to the owning cache. Sits between caches and bus bridge.
// PARAMETERS
// W       4   words per cache line (burst length for line transfers); power of two, 2..16
// LOG_W   2   log2(W); beat counter width
// PORTS
// clk                 in   1     clock
// resetn              in   1     synchronous active-low reset
// i_rd_req/d_rd_req   in   1     cache read request (level, held until matching *_rd_rdy)
// i_rd_type/d_rd_type in   3     3'b100 = line (W beats), 3'b000/001/010 = single beat (B/H/W)
// i_rd_addr/d_rd_addr in   32    read address; line reads are line-aligned by requester
// i_rd_rdy/d_rd_rdy   out  1     request accepted (1-cycle pulse, same cycle as grant)
// i_ret_valid/d_ret_valid out 1  returned beat valid for that cache
// ret_last            out  1     last beat of current read (qualified by *_ret_valid)
// ret_data            out  32    returned beat, shared by both caches
// d_wr_req            in   1     D-cache write request (level, held until d_wr_rdy)
// d_wr_type           in   3     3'b100 = line write-back (W beats), else single beat
// d_wr_addr           in   32    write address
// d_wr_wstrb          in   4     byte strobe for single-beat write; ignored for lines (4'hf)
// d_wr_data           in   32*W  line data, word 0 in [31:0]; single beat uses [31:0]
// d_wr_rdy            out  1     write accepted, d_wr_* captured (1-cycle pulse)
// mem_req             out  1     address phase valid; held until mem_ack
// mem_we              out  1     1 = write transaction
// mem_addr            out  32    transaction start address
// mem_len             out  LOG_W beats-1 (W-1 for line, 0 for single)
// mem_size            out  3     rd_type/wr_type low bits (2'b10 size for lines)
// mem_ack             in   1     address phase accepted
// mem_rvalid/mem_rlast in  1     read beat valid / final beat
// mem_rdata           in   32    read beat data
// mem_wvalid/mem_wlast out 1     write beat valid / final beat
// mem_wdata/mem_wstrb out  32/4  write beat data / strobe
// mem_wready          in   1     write beat accepted
// mem_bvalid          in   1     write response (transaction complete)
// BEHAVIOUR
// - FSM: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP. One transaction in flight.
// - IDLE priority: d_wr_req > round-robin(i_rd_req, d_rd_req). Write first so a write-back precedes
//   the refill of the same line. RR pointer flips to other reader after each read grant; reset: I-cache first.
// - Grant cycle (IDLE): pulse winner's *_rd_rdy/d_wr_rdy combinationally; latch addr/type/len/owner
//   (and d_wr_data/wstrb); next state RD_ADDR or WR_ADDR. No grant when no request.
// - RD_ADDR: mem_req=1, mem_we=0 until mem_ack -> RD_DATA. RD_DATA: each mem_rvalid forwards
//   mem_rdata to ret_data with owner's *_ret_valid in same cycle (combinational); ret_last=mem_rlast;
//   mem_rvalid&mem_rlast -> IDLE. Other owner's ret_valid stays 0.
// - WR_ADDR: mem_req=1, mem_we=1 until mem_ack -> WR_DATA. WR_DATA: mem_wvalid=1, beat k =
//   latched word k; counter advances on mem_wready; mem_wlast on beat len; final accept -> WR_RESP.
//   Line: wstrb 4'hf; single: latched d_wr_wstrb. WR_RESP: wait mem_bvalid -> IDLE.
// - Latency: grant to mem_req 1 cycle; mem_bvalid/rlast to next grant 1 cycle (IDLE).
// - Requests arriving mid-transaction are held by requester; no rdy until IDLE.
// - Beat counter wraps only at len; mem_rvalid outside RD_DATA ignored.
// - Reset (incl. mid-transaction): state IDLE, all outputs 0, counter 0, RR pointer -> I-cache.
//   In-flight memory transaction is abandoned; memory side is reset together.
// TESTING
// - I-cache line read 0x1000, mem returns 4 beats A..D -> i_rd_rdy 1 pulse, i_ret_valid x4 data A..D, ret_last on D, d_ret_valid 0.
// - d_wr_req (line 0x2000, data {4,3,2,1}) and d_rd_req same cycle -> d_wr_rdy first; wdata 1,2,3,4,
//   wlast on 4; after bvalid, d_rd_rdy next cycle.
// - i_rd_req and d_rd_req held continuously -> grants alternate I,D,I,D starting with I.
// - Single write wstrb 4'b0011 addr 0x30 -> mem_len 0, one beat, mem_wstrb 4'b0011, mem_wlast 1.
// - mem_wready low 3 cycles on beat 2 -> mem_wdata holds word 2, counter stalls, no beat lost.
// - resetn low during RD_DATA beat 2 -> next cycle IDLE, all outputs 0; next grant goes to I-cache.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one word-serial memory port between I-cache refills and D-cache refills/write-backs
// One transaction in flight; D-cache writes win over reads, reads alternate round-robin.
module cache_mem_arbiter #(
  parameter int W     = 4,
  parameter int LOG_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_rd_req_i,
  input  logic [2:0]         i_rd_type_i,
  input  logic [31:0]        i_rd_addr_i,
  output logic               i_rd_rdy_o,
  input  logic               d_rd_req_i,
  input  logic [2:0]         d_rd_type_i,
  input  logic [31:0]        d_rd_addr_i,
  output logic               d_rd_rdy_o,
  output logic               i_ret_valid_o,
  output logic               d_ret_valid_o,
  output logic               ret_last_o,
  output logic [31:0]        ret_data_o,
  input  logic               d_wr_req_i,
  input  logic [2:0]         d_wr_type_i,
  input  logic [31:0]        d_wr_addr_i,
  input  logic [3:0]         d_wr_wstrb_i,
  input  logic [32*W-1:0]    d_wr_data_i,
  output logic               d_wr_rdy_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [LOG_W-1:0]   mem_len_o,
  output logic [2:0]         mem_size_o,
  input  logic               mem_ack_i,
  input  logic               mem_rvalid_i,
  input  logic               mem_rlast_i,
  input  logic [31:0]        mem_rdata_i,
  output logic               mem_wvalid_o,
  output logic               mem_wlast_o,
  output logic [31:0]        mem_wdata_o,
  output logic [3:0]         mem_wstrb_o,
  input  logic               mem_wready_i,
  input  logic               mem_bvalid_i
);
  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP} state_e;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;        // 1: D-cache wins the next read tie
  logic              owner_q, owner_d;  // 1: D-cache owns the current read
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [LOG_W-1:0]  len_q, len_d;
  logic [LOG_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [32*W-1:0]   wdata_q, wdata_d;

  logic              gnt_wr, gnt_i, gnt_d;
  logic [2:0]        sel_type;
  logic [31:0]       sel_addr;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    if (state_q == S_IDLE && resetn) begin
      if (d_wr_req_i) begin
        gnt_wr = 1'b1;
      end else if (i_rd_req_i && d_rd_req_i) begin
        gnt_i = !rr_q;
        gnt_d = rr_q;
      end else begin
        gnt_i = i_rd_req_i;
        gnt_d = d_rd_req_i;
      end
    end
    sel_type = gnt_d ? d_rd_type_i : i_rd_type_i;
    sel_addr = gnt_d ? d_rd_addr_i : i_rd_addr_i;
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    size_d        = size_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    i_rd_rdy_o    = gnt_i;
    d_rd_rdy_o    = gnt_d;
    d_wr_rdy_o    = gnt_wr;
    i_ret_valid_o = 1'b0;
    d_ret_valid_o = 1'b0;
    ret_last_o    = 1'b0;
    ret_data_o    = 32'd0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = 32'd0;
    mem_len_o     = '0;
    mem_size_o    = 3'd0;
    mem_wvalid_o  = 1'b0;
    mem_wlast_o   = 1'b0;
    mem_wdata_o   = 32'd0;
    mem_wstrb_o   = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_wr) begin
          state_d = S_WR_ADDR;
          addr_d  = d_wr_addr_i;
          wdata_d = d_wr_data_i;
          cnt_d   = '0;
          if (d_wr_type_i == TYPE_LINE) begin
            size_d  = 3'b010;
            len_d   = LOG_W'(W - 1);
            wstrb_d = 4'hf;
          end else begin
            size_d  = d_wr_type_i;
            len_d   = '0;
            wstrb_d = d_wr_wstrb_i;
          end
        end else if (gnt_i || gnt_d) begin
          state_d = S_RD_ADDR;
          owner_d = gnt_d;
          rr_d    = gnt_i;
          addr_d  = sel_addr;
          size_d  = (sel_type == TYPE_LINE) ? 3'b010 : sel_type;
          len_d   = (sel_type == TYPE_LINE) ? LOG_W'(W - 1) : '0;
        end
      end
      S_RD_ADDR, S_WR_ADDR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = (state_q == S_WR_ADDR);
        mem_addr_o = addr_q;
        mem_len_o  = len_q;
        mem_size_o = size_q;
        if (mem_ack_i) state_d = (state_q == S_WR_ADDR) ? S_WR_DATA : S_RD_DATA;
      end
      S_RD_DATA: begin
        if (mem_rvalid_i) begin
          i_ret_valid_o = !owner_q;
          d_ret_valid_o = owner_q;
          ret_last_o    = mem_rlast_i;
          ret_data_o    = mem_rdata_i;
          if (mem_rlast_i) state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        mem_wvalid_o = 1'b1;
        mem_wlast_o  = (cnt_q == len_q);
        mem_wdata_o  = wdata_q[{cnt_q, 5'b0} +: 32];
        mem_wstrb_o  = wstrb_q;
        if (mem_wready_i) begin
          if (cnt_q == len_q) begin
            state_d = S_WR_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WR_RESP: begin
        if (mem_bvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      wstrb_q <= 4'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized scoreboard bench for cache_mem_arbiter
// Random cache requesters and memory responder; expected grants, bus phases and returned beats are queued and popped by a monitor.
module tb_cache_mem_arbiter;
  localparam int W = 4;
  localparam int LOG_W = 2;
  localparam logic [2:0] LINE = 3'b100;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic             i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
  logic [2:0]       i_rd_type = 3'd0, d_rd_type = 3'd0, d_wr_type = 3'd0;
  logic [31:0]      i_rd_addr = 32'd0, d_rd_addr = 32'd0, d_wr_addr = 32'd0;
  logic [3:0]       d_wr_wstrb = 4'd0;
  logic [32*W-1:0]  d_wr_data = '0;
  logic             mem_ack = 1'b0, mem_rvalid = 1'b0, mem_rlast = 1'b0;
  logic             mem_wready = 1'b0, mem_bvalid = 1'b0;
  logic [31:0]      mem_rdata = 32'd0;
  logic             i_rd_rdy, d_rd_rdy, d_wr_rdy, i_ret_valid, d_ret_valid, ret_last;
  logic [31:0]      ret_data, mem_addr, mem_wdata;
  logic             mem_req, mem_we, mem_wvalid, mem_wlast;
  logic [LOG_W-1:0] mem_len;
  logic [2:0]       mem_size;
  logic [3:0]       mem_wstrb;

  cache_mem_arbiter #(.W(W), .LOG_W(LOG_W)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req_i(i_rd_req), .i_rd_type_i(i_rd_type), .i_rd_addr_i(i_rd_addr), .i_rd_rdy_o(i_rd_rdy),
    .d_rd_req_i(d_rd_req), .d_rd_type_i(d_rd_type), .d_rd_addr_i(d_rd_addr), .d_rd_rdy_o(d_rd_rdy),
    .i_ret_valid_o(i_ret_valid), .d_ret_valid_o(d_ret_valid), .ret_last_o(ret_last), .ret_data_o(ret_data),
    .d_wr_req_i(d_wr_req), .d_wr_type_i(d_wr_type), .d_wr_addr_i(d_wr_addr), .d_wr_wstrb_i(d_wr_wstrb),
    .d_wr_data_i(d_wr_data), .d_wr_rdy_o(d_wr_rdy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_len_o(mem_len), .mem_size_o(mem_size),
    .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rlast_i(mem_rlast), .mem_rdata_i(mem_rdata),
    .mem_wvalid_o(mem_wvalid), .mem_wlast_o(mem_wlast), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_wready_i(mem_wready), .mem_bvalid_i(mem_bvalid)
  );

  typedef struct { logic we; logic [31:0] addr; logic [LOG_W-1:0] len; logic [2:0] size; } txn_t;
  typedef struct { logic we; logic owner; int nbeats; } job_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct { logic owner; logic [31:0] data; logic last; } ret_t;

  txn_t   exp_txn[$];
  job_t   jobs[$];
  wbeat_t exp_w[$];
  ret_t   exp_ret[$];

  int  n_chk = 0, n_fail = 0, n_rd = 0, n_wr = 0;
  bit  mon_en = 0, stop = 0, mdl_stop = 0, busy = 0, d_turn = 0, i_done = 0, d_done = 0;
  logic [2:0]  exp_g;
  logic        wline, rowner;
  logic [2:0]  rtype;
  logic [31:0] raddr;
  int          nb;
  txn_t        t;
  wbeat_t      wb;
  ret_t        rb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, 32'({i_rd_rdy, d_rd_rdy, d_wr_rdy, i_ret_valid, d_ret_valid, ret_last,
                               mem_req, mem_we, mem_wvalid, mem_wlast}), 32'd0);
    check({tag, "_ret_data"}, ret_data, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_len_size_strb"}, 32'({mem_len, mem_size, mem_wstrb}), 32'd0);
  endtask

  // Reference model: which request must win, and what each granted request must look like on the bus.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_g = 3'b000;
      if (!busy) begin
        if (d_wr_req) exp_g = 3'b001;
        else if (i_rd_req && d_rd_req) exp_g = d_turn ? 3'b010 : 3'b100;
        else exp_g = {i_rd_req, d_rd_req, 1'b0};
      end
      check("grant", 32'({i_rd_rdy, d_rd_rdy, d_wr_rdy}), 32'(exp_g));
      if (exp_g == 3'b001) begin
        wline = (d_wr_type == LINE);
        nb = wline ? W : 1;
        exp_txn.push_back('{1'b1, d_wr_addr, wline ? LOG_W'(W - 1) : LOG_W'(0), wline ? 3'b010 : d_wr_type});
        for (int k = 0; k < nb; k++)
          exp_w.push_back('{d_wr_data[32*k +: 32], wline ? 4'hf : d_wr_wstrb, k == nb - 1});
        jobs.push_back('{1'b1, 1'b0, nb});
        busy = 1'b1;
        n_wr++;
      end else if (exp_g != 3'b000) begin
        rowner = exp_g[1];
        rtype  = rowner ? d_rd_type : i_rd_type;
        raddr  = rowner ? d_rd_addr : i_rd_addr;
        nb = (rtype == LINE) ? W : 1;
        exp_txn.push_back('{1'b0, raddr, (rtype == LINE) ? LOG_W'(W - 1) : LOG_W'(0),
                            (rtype == LINE) ? 3'b010 : rtype});
        jobs.push_back('{1'b0, rowner, nb});
        d_turn = exp_g[2];
        busy = 1'b1;
        n_rd++;
      end
      if (mem_bvalid || (mem_rvalid && mem_rlast)) busy = 1'b0;

      if (mem_req && mem_ack) begin
        if (exp_txn.size() == 0) check("unexpected_txn", 32'(mem_req), 32'd0);
        else begin
          t = exp_txn.pop_front();
          check("mem_we", 32'(mem_we), 32'(t.we));
          check("mem_addr", mem_addr, t.addr);
          check("mem_len", 32'(mem_len), 32'(t.len));
          check("mem_size", 32'(mem_size), 32'(t.size));
        end
      end
      if (mem_wvalid && mem_wready) begin
        if (exp_w.size() == 0) check("unexpected_wbeat", 32'(mem_wvalid), 32'd0);
        else begin
          wb = exp_w.pop_front();
          check("mem_wdata", mem_wdata, wb.data);
          check("mem_wstrb_wlast", 32'({mem_wstrb, mem_wlast}), 32'({wb.strb, wb.last}));
        end
      end
      if (i_ret_valid || d_ret_valid) begin
        if (exp_ret.size() == 0) check("unexpected_ret", 32'({i_ret_valid, d_ret_valid}), 32'd0);
        else begin
          rb = exp_ret.pop_front();
          check("ret_owner", 32'({i_ret_valid, d_ret_valid}), rb.owner ? 32'd1 : 32'd2);
          check("ret_data", ret_data, rb.data);
          check("ret_last", 32'(ret_last), 32'(rb.last));
        end
      end
    end
  end

  task automatic req_i();
    int g;
    logic gs;
    while (!stop) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      i_rd_type = ($urandom_range(0, 1) != 0) ? LINE : 3'($urandom_range(0, 2));
      i_rd_addr = $urandom & ((i_rd_type == LINE) ? 32'hffff_fff0 : 32'hffff_ffff);
      i_rd_req = 1'b1;
      g = 0;
      while (i_rd_req) begin
        @(negedge clk); gs = i_rd_rdy;
        @(posedge clk); #1;
        g++;
        if (gs) i_rd_req = 1'b0;
        else if (g > 2000) begin check("i_grant_timeout", 32'(gs), 32'd1); i_rd_req = 1'b0; end
      end
    end
    i_done = 1'b1;
  endtask

  task automatic req_d();
    int g, mode;
    logic gr, gw;
    while (!stop) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      mode = $urandom_range(0, 3);
      if (mode != 1) begin
        d_rd_type = ($urandom_range(0, 1) != 0) ? LINE : 3'($urandom_range(0, 2));
        d_rd_addr = $urandom & ((d_rd_type == LINE) ? 32'hffff_fff0 : 32'hffff_ffff);
        d_rd_req = 1'b1;
      end
      if (mode != 0) begin
        d_wr_type  = ($urandom_range(0, 1) != 0) ? LINE : 3'($urandom_range(0, 2));
        d_wr_addr  = $urandom & ((d_wr_type == LINE) ? 32'hffff_fff0 : 32'hffff_ffff);
        d_wr_wstrb = 4'($urandom_range(1, 15));
        for (int k = 0; k < W; k++) d_wr_data[32*k +: 32] = $urandom;
        d_wr_req = 1'b1;
      end
      g = 0;
      while (d_rd_req || d_wr_req) begin
        @(negedge clk); gr = d_rd_rdy; gw = d_wr_rdy;
        @(posedge clk); #1;
        g++;
        if (gr) d_rd_req = 1'b0;
        if (gw) d_wr_req = 1'b0;
        if (g > 2000) begin
          check("d_grant_timeout", 32'({d_rd_req, d_wr_req}), 32'd0);
          d_rd_req = 1'b0; d_wr_req = 1'b0;
        end
      end
    end
    d_done = 1'b1;
  endtask

  task automatic mem_model();
    job_t j;
    int g;
    bit fin;
    while (!mdl_stop) begin
      @(posedge clk); #1;
      if (mem_req && jobs.size() > 0) begin
        j = jobs.pop_front();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (j.we) begin
          g = 0; fin = 0;
          while (!fin && g < 500) begin
            mem_wready = ($urandom_range(0, 2) != 0);
            mem_rvalid = 1'($urandom_range(0, 1));   // stray read beats must not reach the caches
            mem_rdata  = $urandom;
            @(negedge clk); fin = mem_wvalid && mem_wready && mem_wlast;
            @(posedge clk); #1;
            g++;
          end
          if (!fin) check("wbeat_timeout", 32'(fin), 32'd1);
          mem_wready = 1'b0; mem_rvalid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          mem_bvalid = 1'b1;
          @(posedge clk); #1;
          mem_bvalid = 1'b0;
        end else begin
          for (int k = 0; k < j.nbeats; k++) begin
            while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            mem_rlast  = (k == j.nbeats - 1);
            exp_ret.push_back('{j.owner, mem_rdata, mem_rlast});
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
          end
        end
      end
    end
  endtask

  int g;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); check_quiet("in_reset");
    @(posedge clk); #1; resetn = 1'b1;
    @(negedge clk); check_quiet("after_reset");
    mon_en = 1'b1;
    fork
      req_i();
      req_d();
      mem_model();
      begin
        repeat (6000) @(posedge clk);
        stop = 1'b1;
        g = 0;
        while (!(i_done && d_done && !busy) && g < 6000) begin @(posedge clk); g++; end
        check("drain", 32'({i_done, d_done, busy}), 32'b110);
        repeat (4) @(posedge clk);
        mdl_stop = 1'b1;
      end
    join
    check("txn_left", 32'(exp_txn.size()), 32'd0);
    check("wbeat_left", 32'(exp_w.size()), 32'd0);
    check("ret_left", 32'(exp_ret.size()), 32'd0);
    check("traffic_seen", 32'({n_rd > 50, n_wr > 20}), 32'b11);
    mon_en = 1'b0;

    // Reset in the middle of an I-cache refill; afterwards the I-cache must win a tie again.
    @(posedge clk); #1;
    i_rd_type = LINE; i_rd_addr = 32'h1000; i_rd_req = 1'b1;
    @(negedge clk); check("rst_i_grant", 32'({i_rd_rdy, d_rd_rdy, d_wr_rdy}), 32'b100);
    @(posedge clk); #1; i_rd_req = 1'b0;
    @(negedge clk); check("rst_mem_req", 32'({mem_req, mem_we}), 32'b10);
    check("rst_mem_addr", mem_addr, 32'h1000);
    @(posedge clk); #1; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA;
    @(negedge clk); check("rst_beat0_flags", 32'({i_ret_valid, d_ret_valid, ret_last}), 32'b100);
    check("rst_beat0_data", ret_data, 32'hA);
    @(posedge clk); #1; mem_rdata = 32'hB;
    @(posedge clk); #1; mem_rdata = 32'hC; resetn = 1'b0;
    @(posedge clk); #1; resetn = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk); check_quiet("post_mid_reset");
    @(posedge clk); #1;
    i_rd_type = LINE; i_rd_addr = 32'h2000; i_rd_req = 1'b1;
    d_rd_type = LINE; d_rd_addr = 32'h3000; d_rd_req = 1'b1;
    @(negedge clk); check("rst_rr_i_first", 32'({i_rd_rdy, d_rd_rdy}), 32'b10);
    @(posedge clk); #1; i_rd_req = 1'b0; d_rd_req = 1'b0; resetn = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
